// File: rtl/instr_issuer.sv
// Sequential instruction issuer: replays a small program buffer to a compute unit,
// one instruction at a time, accumulating a checksum of the matching responses.
module instr_issuer #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        prog_we,
  input  logic [2:0]  prog_addr,
  input  logic [15:0] prog_data,
  input  logic [3:0]  prog_len,
  input  logic        start,
  input  logic [7:0]  rsp_data,
  input  logic        rsp_valid,
  input  logic [3:0]  rsp_reg_id,
  output logic [15:0] instruction,
  output logic        en,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  checksum,
  output logic [3:0]  issued_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIN} state_e;

  localparam logic [3:0]     DEPTH_L = 4'(DEPTH);
  localparam int unsigned    WW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WW-1:0]  WLAST   = WW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [15:0]   buf_q [8];
  logic [3:0]    pc_q, pc_d;
  logic [3:0]    len_q, len_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [15:0]   instr_q, instr_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    sum_q, sum_d;
  logic          err_q, err_d;
  logic          expect_rsp;
  logic          advance;
  logic [3:0]    pc_inc;

  // Program storage is deliberately left out of reset so a program survives an abort.
  always_ff @(posedge clk) begin
    if (!rstn && state_q == S_IDLE && prog_we && ({1'b0, prog_addr} < DEPTH_L)) begin
      buf_q[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      wcnt_q  <= '0;
      instr_q <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  end

  // instr_q is loaded on entry to ISSUE, so it shows buffer[pc] during ISSUE and holds afterwards.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    len_d      = len_q;
    wcnt_d     = wcnt_q;
    instr_d    = instr_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    err_d      = err_q;
    advance    = 1'b0;
    pc_inc     = pc_q + 4'd1;
    expect_rsp = (instr_q[15:12] != 4'h0) && !instr_q[15];

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d  = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
          pc_d   = '0;
          cnt_d  = '0;
          sum_d  = '0;
          err_d  = 1'b0;
          wcnt_d = '0;
          if (len_d == 4'd0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_ISSUE;
            instr_d = buf_q[3'd0];
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = cnt_q + 4'd1;
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A matching response wins over a timeout expiring in the same cycle.
        if (!expect_rsp) begin
          advance = 1'b1;
        end else if (rsp_valid && rsp_reg_id == instr_q[11:8]) begin
          sum_d   = sum_q + rsp_data;
          advance = 1'b1;
        end else if (wcnt_q == WLAST) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
        if (advance) begin
          pc_d = pc_inc;
          if (pc_inc < len_q) begin
            state_d = S_ISSUE;
            instr_d = buf_q[pc_inc[2:0]];
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign instruction = instr_q;
  assign en          = (state_q == S_ISSUE);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);
  assign err         = err_q;
  assign checksum    = sum_q;
  assign issued_cnt  = cnt_q;

endmodule

// File: tb/tb_instr_issuer.sv
// Directed and randomized program runs against a per-entry behavioural model
// of issue count, checksum, timeout error and start-to-done latency.
module tb_instr_issuer;

  localparam int unsigned DEPTH   = 6;
  localparam int unsigned TIMEOUT = 3;

  logic        clk = 1'b0;
  logic        rstn, prog_we, start, rsp_valid;
  logic [2:0]  prog_addr;
  logic [15:0] prog_data;
  logic [3:0]  prog_len, rsp_reg_id;
  logic [7:0]  rsp_data;
  logic [15:0] instruction;
  logic        en, busy, done, err;
  logic [7:0]  checksum;
  logic [3:0]  issued_cnt;

  always #5 clk = ~clk;

  instr_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .start(start),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_reg_id(rsp_reg_id),
    .instruction(instruction), .en(en), .busy(busy), .done(done), .err(err),
    .checksum(checksum), .issued_cnt(issued_cnt)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Model program buffer and per-entry response plan:
  // dly = WAIT cycle (1-based) in which the correct response is driven, > TIMEOUT means never.
  logic [15:0] mem   [8];
  int unsigned dly   [8];
  logic [7:0]  dat   [8];
  bit          wrong [8];
  logic [15:0] last_instr = '0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick;
    prog_we = 1'b0;
    if (int'(a) < DEPTH) mem[a] = d;
  endtask

  function automatic bit expects_rsp(input logic [15:0] ins);
    int unsigned op;
    op = int'(ins[15:12]);
    return (op >= 1 && op <= 7);
  endfunction

  task automatic run(input string tag, input logic [3:0] L);
    int unsigned lm, exp_iss, exp_edges, edges, nen, k, wpos;
    logic [7:0]  exp_sum;
    bit          exp_err, waiting;
    lm = (int'(L) > DEPTH) ? DEPTH : int'(L);
    exp_sum = '0; exp_iss = 0; exp_err = 1'b0; exp_edges = 1;
    for (int unsigned i = 0; i < lm; i++) begin
      exp_iss++;
      if (!expects_rsp(mem[i])) begin
        exp_edges += 2;
      end else if (dly[i] <= TIMEOUT) begin
        exp_sum += dat[i];
        exp_edges += 1 + dly[i];
      end else begin
        exp_err = 1'b1;
        exp_edges += 1 + TIMEOUT;
        break;
      end
    end

    prog_len = L; start = 1'b1;
    tick;
    start = 1'b0;
    edges = 1; nen = 0; k = 0; wpos = 0; waiting = 1'b0;
    while (done !== 1'b1 && edges < 200) begin
      rsp_valid = 1'b0; rsp_reg_id = 4'($urandom); rsp_data = 8'($urandom);
      prog_we = 1'b1; prog_addr = 3'($urandom); prog_data = 16'($urandom);
      start = 1'($urandom);
      if (en === 1'b1) begin
        if (nen < 8) check({tag, "_instr"}, 32'(instruction), 32'(mem[nen]));
        else check({tag, "_extra_en"}, nen, 7);
        k = nen % 8; nen++; waiting = 1'b1; wpos = 0;
      end else if (waiting) begin
        wpos++;
        if (wpos == dly[k]) begin
          rsp_valid = 1'b1; rsp_reg_id = mem[k][11:8]; rsp_data = dat[k];
        end else if (wrong[k] && wpos + 1 == dly[k]) begin
          rsp_valid = 1'b1; rsp_reg_id = mem[k][11:8] ^ 4'(1 + $urandom_range(14));
        end
      end
      tick;
      edges++;
    end
    prog_we = 1'b0; rsp_valid = 1'b0; start = 1'b0;

    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_latency"}, edges, exp_edges);
    check({tag, "_busy_fin"}, 32'(busy), 1);
    check({tag, "_en_count"}, nen, exp_iss);
    check({tag, "_issued"}, 32'(issued_cnt), exp_iss);
    check({tag, "_checksum"}, 32'(checksum), 32'(exp_sum));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    if (exp_iss > 0) last_instr = mem[exp_iss - 1];
    tick;
    tick;
    check({tag, "_done_pulse"}, 32'(done), 0);
    check({tag, "_idle"}, 32'(busy), 0);
    check({tag, "_hold"}, {8'(issued_cnt), 8'(checksum), 8'(err)},
          {8'(exp_iss), exp_sum, 8'(exp_err)});
    check({tag, "_instr_hold"}, 32'(instruction), 32'(last_instr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
    start = 1'b0; rsp_data = '0; rsp_valid = 1'b0; rsp_reg_id = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      mem[i] = '0; dly[i] = 1; dat[i] = '0; wrong[i] = 1'b0;
    end
    tick; tick;
    check("reset_outs", {instruction, 3'b0, en, busy, done, err, 1'b0},
          {16'h0, 3'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    check("reset_cnt", {8'(checksum), 8'(issued_cnt)}, 0);
    rstn = 1'b0;
    tick;

    // Three-entry program, each response one cycle after en.
    load(0, 16'h1105); load(1, 16'h1203); load(2, 16'h2312);
    dat[0] = 8'd5; dat[1] = 8'd3; dat[2] = 8'd8;
    run("basic", 4'd3);
    check("basic_sum_const", 32'(checksum), 32'h10);

    run("len0", 4'd0);

    // Entry with no response: timeout and remaining entries dropped.
    load(0, 16'h2312); dly[0] = TIMEOUT + 1;
    run("timeout", 4'd3);

    // NOP followed by a response-carrying entry.
    load(0, 16'h0000); load(1, 16'h1401);
    dly[0] = 1; dly[1] = 1; dat[1] = 8'h01;
    run("nop", 4'd2);

    // Wrong reg id first, correct id one cycle later.
    load(0, 16'h1301); dly[0] = 2; wrong[0] = 1'b1; dat[0] = 8'h5A;
    run("wrong_id", 4'd1);
    wrong[0] = 1'b0;

    // Response arriving on the last permitted WAIT cycle.
    load(0, 16'h1200); dly[0] = TIMEOUT; dat[0] = 8'hC3;
    run("late_ok", 4'd1);

    // prog_len beyond DEPTH is clamped.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      load(3'(i), {4'h9, 12'($urandom)}); dly[i] = 1;
    end
    run("clamp", 4'd15);

    // Abort by reset in the WAIT of entry 1; reset also beats start and prog_we.
    load(0, 16'h0000); load(1, 16'h1305); load(2, 16'h1102);
    prog_len = 4'd3; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    check("abort_en1", {15'b0, en, 15'b0, 1'(instruction == 16'h1305)}, {15'b0, 1'b1, 15'b0, 1'b1});
    tick;
    check("abort_wait", {8'(busy), 8'(en), 16'(issued_cnt)}, {8'd1, 8'd0, 16'd2});
    rstn = 1'b1; start = 1'b1; prog_we = 1'b1; prog_addr = 3'd1; prog_data = 16'hFFFF;
    tick;
    check("abort_reset", {instruction, 4'(en), 4'(busy), 4'(done), 4'(err)}, 32'h0);
    check("abort_reset_cnt", {8'(checksum), 8'(issued_cnt)}, 0);
    rstn = 1'b0; start = 1'b0; prog_we = 1'b0;
    tick;
    check("abort_no_done", {8'(done), 8'(busy)}, 0);
    last_instr = '0;
    dly[0] = 1; dly[1] = 1; dly[2] = 1; dat[1] = 8'h21; dat[2] = 8'h13;
    run("restart", 4'd3);

    // Randomized programs and response plans.
    for (int r = 0; r < 30; r++) begin
      for (int unsigned n = 0; n < 6; n++) load(3'($urandom), 16'($urandom));
      for (int unsigned i = 0; i < 8; i++) begin
        dly[i]   = ($urandom_range(5) == 0) ? TIMEOUT + 1 : 1 + $urandom_range(TIMEOUT - 1);
        dat[i]   = 8'($urandom);
        wrong[i] = 1'($urandom);
      end
      run($sformatf("rnd%0d", r), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
